instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues word reads to instruction memory over a request/ready handshake, and drives the fetch-side inputs of the IF/ID pipeline register (instruction, PC+4, valid). It absorbs variable memory latency, decode-stage stalls (via a one-entry skid buffer) and branch/jump redirects (with flush of wrong-path instructions). It sits between instruction memory and IF/ID, and takes stall/redirect from the hazard and branch logic.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- stall  in  1  decode not accepting; output register must hold when validOut=1
- redirect  in  1  branch/jump taken; dominates stall
- redirectPC  in  32  redirect target; bits [1:0] ignored (treated as 0)
- imemReq  out  1  read request to instruction memory
- imemAddr  out  32  word address of the request
- imemReady  in  1  transfer completes at an edge where imemReq=1 and imemReady=1
- imemData  in  32  read data, valid in the completing cycle only
- instruccionOut  out  32  fetched instruction to IF/ID (0 = NOP when invalid)
- PC4Out  out  32  address of instruccionOut + 4
- validOut  out  1  instruccionOut/PC4Out hold a valid instruction

## Operation
- Registers: pc (next address to fetch), request address, skid instruction + skid PC+4, output register (instruccionOut, PC4Out, validOut), state.
- Handshake: once imemReq rises, imemAddr stays stable and imemReq stays high until the completing edge. One request outstanding at most.
- Output consumed at any edge with validOut=1 and stall=0. Output is "free" if validOut=0 or it is being consumed.
- States:
  - IDLE: imemReq=0. Entered on reset. Next edge -> FETCH.
  - FETCH: imemReq=1, imemAddr=request address (=pc on entry). At edge:
    - redirect=1: flush (below); if imemReady=1 -> FETCH at redirectPC, else -> DROP.
    - imemReady=1, output free: output <= {imemData, addr+4, 1}; pc <= addr+4; stay FETCH.
    - imemReady=1, output not free: skid <= {imemData, addr+4}; pc <= addr+4; -> HOLD.
    - imemReady=0: if output consumed, validOut<=0, instruccionOut<=0.
  - DROP: imemReq=1, imemAddr = old address. Response discarded on completion -> FETCH at pc. Further redirect in DROP updates pc, stays DROP.
  - HOLD: imemReq=0. stall=0 at edge: output <= skid, -> FETCH at pc. redirect: flush, -> FETCH at redirectPC.
- Flush (any state, redirect=1): validOut<=0, instruccionOut<=0, skid discarded, pc<=redirectPC. No delay-slot instruction is kept.
- Consumption with nothing new: validOut<=0, instruccionOut<=0, PC4Out holds.
- Arithmetic: PC+4 modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000.

## Timing
- Reset values (while reset=0): state IDLE, pc=RESET_PC, imemReq=0, imemAddr=RESET_PC, instruccionOut=0, PC4Out=0, validOut=0.
- After reset release: edge 1 IDLE->FETCH (imemReq=1, imemAddr=RESET_PC); with zero-wait memory, edge 2 gives validOut=1, PC4Out=RESET_PC+4.
- Zero-wait throughput: one instruction per cycle, back-to-back requests with no idle cycle.
- Latency: request-completion edge -> output valid the following cycle (1 cycle registered).
- Redirect penalty (zero-wait): redirect edge, then target instruction valid one edge later; validOut=0 for exactly one cycle.
- Reset asserted mid-transfer: all outputs go to reset values asynchronously; the in-flight request is abandoned.

## Test plan
- Reset/stream: RESET_PC=0, imemReady=1, memory word = address ^ 0xA5A5_0000 -> from edge 2, PC4Out = 4, 8, 12..., instruccionOut matching, validOut continuously 1.
- Wait states: imemReady high 2 cycles after each request -> imemAddr held 3 cycles per word, validOut pulses for 1 cycle every 3, no duplicates.
- Stall/skid: stall=1 while validOut=1 and a response completes -> HOLD, imemReq=0, outputs frozen; stall=0 -> skid word appears, next request at addr+4, sequence gap-free.
- Redirect in flight: request 0x10 pending (imemReady=0), redirect to 0x400 -> imemAddr stays 0x10 until ready, that data discarded, next request 0x400, next valid PC4Out=0x404.
- Redirect+stall in HOLD -> validOut=0, skid dropped, fetch resumes at redirectPC; redirectPC=0xFFFF_FFFC -> PC4Out=0, next imemAddr=0.
- Async reset mid-request: reset=0 while imemReq=1 -> imemReq=0, validOut=0, imemAddr=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/ready bus.
// Master drives imemReq/imemAddr; slave returns imemReady/imemData.
interface instruction_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemData
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns PC, reads imem, feeds IF/ID with a one-entry skid.
// Ports: clk, reset (async low), stall, redirect/redirectPC, imem bus, IF/ID outputs.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirectPC,
  instruction_fetch_if.master        imem,
  output logic [31:0]                instruccionOut,
  output logic [31:0]                PC4Out,
  output logic                       validOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [31:0] r_skid_ins;
  logic [31:0] r_skid_pc4;
  logic [31:0] r_ins;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic [31:0] w_tgt;
  logic [31:0] w_nxt;
  logic        w_done;
  logic        w_consume;
  logic        w_free;

  assign w_tgt     = {redirectPC[31:2], 2'b00};
  assign w_nxt     = r_addr + 32'd4;
  assign w_done    = r_req & imem.imemReady;
  assign w_consume = r_valid & ~stall;
  assign w_free    = ~r_valid | w_consume;

  assign imem.imemReq  = r_req;
  assign imem.imemAddr = r_addr;
  assign instruccionOut = r_ins;
  assign PC4Out         = r_pc4;
  assign validOut       = r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_skid_ins <= '0;
      r_skid_pc4 <= '0;
      r_ins      <= '0;
      r_pc4      <= '0;
      r_valid    <= 1'b0;
    end else begin
      // Consumed with nothing new: becomes a NOP, PC4Out holds.
      if (w_consume) begin
        r_valid <= 1'b0;
        r_ins   <= '0;
      end
      if (redirect) begin
        r_valid <= 1'b0;
        r_ins   <= '0;
        r_pc    <= w_tgt;
        // An unfinished request must run to completion before
        // the target can be issued; its data is dropped.
        if (r_req && !imem.imemReady) begin
          r_state <= S_DROP;
        end else begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_addr  <= w_tgt;
        end
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          S_FETCH: begin
            if (w_done) begin
              r_pc <= w_nxt;
              if (w_free) begin
                r_ins   <= imem.imemData;
                r_pc4   <= w_nxt;
                r_valid <= 1'b1;
                r_addr  <= w_nxt;
              end else begin
                r_skid_ins <= imem.imemData;
                r_skid_pc4 <= w_nxt;
                r_state    <= S_HOLD;
                r_req      <= 1'b0;
              end
            end
          end
          S_DROP: begin
            if (w_done) begin
              r_state <= S_FETCH;
              r_addr  <= r_pc;
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_ins   <= r_skid_ins;
              r_pc4   <= r_skid_pc4;
              r_valid <= 1'b1;
              r_state <= S_FETCH;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch.
// Reference: expected in-order instruction stream driven by redirects.
module tb_instruction_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = '0;
  logic [31:0] instruccionOut;
  logic [31:0] PC4Out;
  logic        validOut;

  instruction_fetch_if imem ();

  instruction_fetch #(.RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirectPC     (redirectPC),
    .imem           (imem),
    .instruccionOut (instruccionOut),
    .PC4Out         (PC4Out),
    .validOut       (validOut)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drive one cycle; model the accepted stream at the edge.
  task automatic step(input logic rdy, input logic stl,
                      input logic rd, input logic [31:0] tgt);
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc4;
    imem.imemReady = rdy;
    stall          = stl;
    redirect       = rd;
    redirectPC     = tgt;
    imem.imemData  = rdy ? (imem.imemAddr ^ K) : $urandom;
    v   = validOut;
    ins = instruccionOut;
    pc4 = PC4Out;
    @(posedge clk);
    #1;
    if (rd) begin
      exp_pc = {tgt[31:2], 2'b00};
      chk("flush_valid", {31'd0, validOut}, 32'd0);
    end else if (v && !stl) begin
      chk("acc_ins", ins, exp_pc ^ K);
      chk("acc_pc4", pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end else if (v && stl) begin
      chk("hold_valid", {31'd0, validOut}, 32'd1);
    end
  endtask

  initial begin
    int nv;
    imem.imemReady = 1'b0;
    imem.imemData  = '0;
    exp_pc = 32'h0;
    #12;
    chk("rst_req",   {31'd0, imem.imemReq}, 32'd0);
    chk("rst_addr",  imem.imemAddr, 32'h0);
    chk("rst_ins",   instruccionOut, 32'h0);
    chk("rst_pc4",   PC4Out, 32'h0);
    chk("rst_valid", {31'd0, validOut}, 32'd0);
    reset = 1'b1;

    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("e1_req",   {31'd0, imem.imemReq}, 32'd1);
    chk("e1_addr",  imem.imemAddr, 32'h0);
    chk("e1_valid", {31'd0, validOut}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("e2_valid", {31'd0, validOut}, 32'd1);
    chk("e2_pc4",   PC4Out, 32'h4);
    chk("e2_ins",   instruccionOut, 32'h0 ^ K);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stream_valid", {31'd0, validOut}, 32'd1);
    end

    nv = 0;
    for (int i = 0; i < 9; i++) begin
      step((i % 3) == 2, 1'b0, 1'b0, 32'h0);
      nv += int'(validOut);
    end
    chk("wait_pulses", nv, 32'd3);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_req", {31'd0, imem.imemReq}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_req",   {31'd0, imem.imemReq}, 32'd0);
    chk("arst_valid", {31'd0, validOut}, 32'd0);
    chk("arst_addr",  imem.imemAddr, 32'h0);
    chk("arst_ins",   instruccionOut, 32'h0);
    reset  = 1'b1;
    exp_pc = 32'h0;

    for (int k = 0; k < 20 && imem.imemAddr !== 32'h10; k++)
      step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reach_10", imem.imemAddr, 32'h10);
    step(1'b0, 1'b0, 1'b1, 32'h400);
    chk("rdf_addr",  imem.imemAddr, 32'h10);
    chk("rdf_req",   {31'd0, imem.imemReq}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rdf_addr2", imem.imemAddr, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drop_addr",  imem.imemAddr, 32'h400);
    chk("drop_valid", {31'd0, validOut}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("tgt_valid", {31'd0, validOut}, 32'd1);
    chk("tgt_pc4",   PC4Out, 32'h404);
    chk("tgt_addr",  imem.imemAddr, 32'h404);

    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_req", {31'd0, imem.imemReq}, 32'd0);
    chk("hold_pc4", PC4Out, 32'h404);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_req2", {31'd0, imem.imemReq}, 32'd0);
    chk("hold_pc4b", PC4Out, 32'h404);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("skid_pc4",  PC4Out, 32'h408);
    chk("skid_addr", imem.imemAddr, 32'h408);
    chk("skid_req",  {31'd0, imem.imemReq}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold2_req", {31'd0, imem.imemReq}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("hrd_addr", imem.imemAddr, 32'hFFFF_FFFC);
    chk("hrd_req",  {31'd0, imem.imemReq}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_valid", {31'd0, validOut}, 32'd1);
    chk("wrap_pc4",   PC4Out, 32'h0);
    chk("wrap_addr",  imem.imemAddr, 32'h0);

    n_acc = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
           $urandom_range(0, 39) == 0, $urandom);
    chk("liveness", {31'd0, n_acc > 200}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
